// File: rtl/pixel_readout.sv
// pixel_readout: snapshots a frame of 8-bit pixel values and streams them out as valid/ready beats.
// Latency: first beat one cycle after start; done/array_clear one cycle after the final beat transfers.
// Backpressure: out_ready low stalls the stream; payload, index and last hold until the beat transfers.
//
// Ports:
//   clk            - single clock, rising edge
//   reset          - asynchronous active-high reset, forces IDLE and all outputs to 0
//   start          - request one frame readout (only honoured in IDLE, never queued)
//   stored_values  - NUM_PIXELS x 8-bit captured counter values, pixel i at stored_values[i]
//   out_data       - beat payload (0 when out_valid is low)
//   out_index      - pixel number of the beat (0 when out_valid is low)
//   out_valid      - beat valid
//   out_ready      - sink accepts beat
//   out_last       - final beat of the frame
//   busy           - readout in progress (from the cycle after start through FINISH)
//   done           - one-cycle frame-complete pulse
//   array_clear    - one-cycle pulse telling the capture array to clear
//
// Optional feature: define READOUT_CHECKSUM_EN to append one checksum beat
// (sum of snapshot values mod 256, index 0, last=1) after the pixel beats.

module pixel_readout #(
   parameter  int NUM_PIXELS = 1,
   localparam int IDX_W      = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        start,
   input  logic [NUM_PIXELS-1:0][7:0]  stored_values,
   output logic [7:0]                  out_data,
   output logic [IDX_W-1:0]            out_index,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic                        out_last,
   output logic                        busy,
   output logic                        done,
   output logic                        array_clear
);

   // State encoding
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SEND   = 2'd1;
   localparam logic [1:0] ST_FINISH = 2'd2;
`ifdef READOUT_CHECKSUM_EN
   localparam logic [1:0] ST_CKSUM  = 2'd3;
`endif

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PIXELS - 1);

   logic [1:0]                  r_state;
   logic [IDX_W-1:0]            r_idx;
   logic [NUM_PIXELS-1:0][7:0]  r_shadow;
`ifdef READOUT_CHECKSUM_EN
   logic [7:0]                  r_sum;
`endif

   logic [7:0] w_pix;
   logic       w_send;
   logic       w_cksum;
   logic       w_at_last;
   logic       w_xfer;

   // Pixel select from the shadow buffer. Written as a compare loop so that
   // NUM_PIXELS values that are not a power of two (and NUM_PIXELS=1, where
   // the 1-bit index is wider than the array needs) select cleanly.
   always_comb begin
      w_pix = '0;
      for (int i = 0; i < NUM_PIXELS; i++) begin
         if (r_idx == IDX_W'(i)) begin
            w_pix = r_shadow[i];
         end
      end
   end

   assign w_send    = (r_state == ST_SEND);
`ifdef READOUT_CHECKSUM_EN
   assign w_cksum   = (r_state == ST_CKSUM);
`else
   assign w_cksum   = 1'b0;
`endif
   assign w_at_last = (r_idx == LAST_IDX);
   assign w_xfer    = out_valid & out_ready;

   // State, index, snapshot and running checksum.
   // r_idx returns to 0 after the last pixel so IDLE always starts clean.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= ST_IDLE;
         r_idx    <= '0;
         r_shadow <= '0;
`ifdef READOUT_CHECKSUM_EN
         r_sum    <= '0;
`endif
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_shadow <= stored_values;
                  r_idx    <= '0;
`ifdef READOUT_CHECKSUM_EN
                  r_sum    <= '0;
`endif
                  r_state  <= ST_SEND;
               end
            end
            ST_SEND: begin
               if (w_xfer) begin
`ifdef READOUT_CHECKSUM_EN
                  // Accumulate as beats leave; the sum is complete exactly
                  // when the last pixel transfers.
                  r_sum <= r_sum + w_pix;
`endif
                  if (w_at_last) begin
                     r_idx   <= '0;
`ifdef READOUT_CHECKSUM_EN
                     r_state <= ST_CKSUM;
`else
                     r_state <= ST_FINISH;
`endif
                  end else begin
                     r_idx <= r_idx + 1'b1;
                  end
               end
            end
`ifdef READOUT_CHECKSUM_EN
            ST_CKSUM: begin
               if (w_xfer) begin
                  r_state <= ST_FINISH;
               end
            end
`endif
            ST_FINISH: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // Outputs decode straight from registered state, so reset zeroes them
   // in the same cycle it is asserted and they cannot change under stall.
   always_comb begin
      out_valid = w_send | w_cksum;
      out_data  = '0;
      out_index = '0;
      out_last  = 1'b0;
      if (w_send) begin
         out_data  = w_pix;
         out_index = r_idx;
`ifdef READOUT_CHECKSUM_EN
         out_last  = 1'b0;
`else
         out_last  = w_at_last;
`endif
      end
`ifdef READOUT_CHECKSUM_EN
      if (w_cksum) begin
         out_data = r_sum;
         out_last = 1'b1;
      end
`endif
   end

   assign busy        = (r_state != ST_IDLE);
   assign done        = (r_state == ST_FINISH);
   assign array_clear = (r_state == ST_FINISH);

endmodule

// File: tb/tb_pixel_readout.sv
// Testbench for pixel_readout: two instances (4 pixels and 1 pixel) driven with
// directed and random frames; expected beats come from a per-frame list model.
module tb_pixel_readout;

   localparam int N4 = 4;
   localparam int W4 = 2;
   localparam int N1 = 1;
   localparam int W1 = 1;
`ifdef READOUT_CHECKSUM_EN
   localparam int CK = 1;
`else
   localparam int CK = 0;
`endif

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic                 start4, valid4, ready4, last4, busy4, done4, clr4;
   logic [N4-1:0][7:0]   vals4;
   logic [7:0]           data4;
   logic [W4-1:0]        idx4;

   logic                 start1, valid1, ready1, last1, busy1, done1, clr1;
   logic [N1-1:0][7:0]   vals1;
   logic [7:0]           data1;
   logic [W1-1:0]        idx1;

   pixel_readout #(.NUM_PIXELS(N4)) u_dut4 (
      .clk(clk), .reset(reset), .start(start4), .stored_values(vals4),
      .out_data(data4), .out_index(idx4), .out_valid(valid4), .out_ready(ready4),
      .out_last(last4), .busy(busy4), .done(done4), .array_clear(clr4)
   );

   pixel_readout #(.NUM_PIXELS(N1)) u_dut1 (
      .clk(clk), .reset(reset), .start(start1), .stored_values(vals1),
      .out_data(data1), .out_index(idx1), .out_valid(valid1), .out_ready(ready1),
      .out_last(last1), .busy(busy1), .done(done1), .array_clear(clr1)
   );

   int tests = 0;
   int fails = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_zero4(input string tag);
      chk({tag, "_data"},  data4,  0);
      chk({tag, "_index"}, idx4,   0);
      chk({tag, "_valid"}, valid4, 0);
      chk({tag, "_last"},  last4,  0);
      chk({tag, "_busy"},  busy4,  0);
      chk({tag, "_done"},  done4,  0);
      chk({tag, "_clr"},   clr4,   0);
   endtask

   // One frame on the 4-pixel instance.
   // rmode: 0 ready always high, 1 random ready, 2 ready low 3 cycles on beat 2.
   // rst_beat >= 0 asserts reset while that beat is presented.
   // restart_cyc > 0 re-pulses start on that cycle of the frame.
   task automatic frame4(input logic [N4-1:0][7:0] v, input int rmode, input bit change,
                         input int rst_beat, input int restart_cyc, input string tag);
      logic [7:0] exp_d[$];
      int         exp_i[$];
      bit         exp_l[$];
      logic [7:0] sum;
      int         ptr, cyc, low_cnt;
      bit         fin, aborted, prev_hold;
      logic [7:0] pd;
      logic [W4-1:0] pi;
      logic       pl;

      sum = 8'd0;
      for (int i = 0; i < N4; i++) begin
         exp_d.push_back(v[i]);
         exp_i.push_back(i);
         exp_l.push_back((CK == 0) && (i == N4 - 1));
         sum = sum + v[i];
      end
      if (CK != 0) begin
         exp_d.push_back(sum);
         exp_i.push_back(0);
         exp_l.push_back(1'b1);
      end

      @(negedge clk);
      chk({tag, "_idle_busy"}, busy4, 0);
      vals4  = v;
      start4 = 1'b1;
      ready4 = 1'b1;
      ptr = 0; cyc = 0; low_cnt = 0;
      fin = 0; aborted = 0; prev_hold = 0;
      pd = '0; pi = '0; pl = 1'b0;

      while (!fin && !aborted && cyc < 100) begin
         @(negedge clk);
         cyc++;
         start4 = (cyc == restart_cyc);
         if (change && cyc == 1) vals4 = {N4{8'hFF}};
         case (rmode)
            0: ready4 = 1'b1;
            1: ready4 = 1'($urandom_range(0, 1));
            default: begin
               if (ptr == 2 && low_cnt < 3) begin
                  ready4 = 1'b0;
                  low_cnt++;
               end else begin
                  ready4 = 1'b1;
               end
            end
         endcase

         if (rst_beat >= 0 && ptr == rst_beat && valid4) begin
            reset = 1'b1;
            #1;
            chk_zero4({tag, "_rst_now"});
            @(negedge clk);
            chk_zero4({tag, "_rst_held"});
            reset  = 1'b0;
            start4 = 1'b0;
            aborted = 1;
         end else begin
            chk({tag, "_busy"}, busy4, 1);
            chk({tag, "_done"}, done4, (ptr == exp_d.size()));
            chk({tag, "_clr"},  clr4,  (ptr == exp_d.size()));
            if (prev_hold) begin
               chk({tag, "_hold_valid"}, valid4, 1);
               chk({tag, "_hold_data"},  data4,  pd);
               chk({tag, "_hold_index"}, idx4,   pi);
               chk({tag, "_hold_last"},  last4,  pl);
            end
            if (valid4) begin
               if (ptr < exp_d.size()) begin
                  chk({tag, "_data"},  data4, exp_d[ptr]);
                  chk({tag, "_index"}, idx4,  exp_i[ptr]);
                  chk({tag, "_last"},  last4, exp_l[ptr]);
               end else begin
                  chk({tag, "_extra_beat"}, valid4, 0);
               end
               if (ready4) ptr++;
            end else begin
               chk({tag, "_idle_data"},  data4, 0);
               chk({tag, "_idle_index"}, idx4,  0);
            end
            if (done4 && ptr == exp_d.size()) begin
               if (rmode == 0) chk({tag, "_latency"}, cyc, N4 + 1 + CK);
               fin = 1;
            end
            prev_hold = valid4 && !ready4;
            pd = data4; pi = idx4; pl = last4;
         end
      end
      start4 = 1'b0;
      if (!fin && !aborted) chk({tag, "_timeout"}, 0, 1);

      // Back in IDLE; a stray start during the frame must not launch another.
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk({tag, "_post_busy"},  busy4,  0);
         chk({tag, "_post_valid"}, valid4, 0);
         chk({tag, "_post_done"},  done4,  0);
         chk({tag, "_post_clr"},   clr4,   0);
      end
   endtask

   initial begin
      logic [N4-1:0][7:0] v;
      logic [7:0] v1;

      reset = 1'b1;
      start4 = 1'b0; ready4 = 1'b0; vals4 = '0;
      start1 = 1'b0; ready1 = 1'b0; vals1 = '0;
      #1;
      chk_zero4("reset4");
      chk("reset1_valid", valid1, 0);
      chk("reset1_busy",  busy1,  0);
      chk("reset1_data",  data1,  0);
      repeat (2) @(negedge clk);
      reset = 1'b0;

      // Basic frame, full throughput.
      v = {8'h40, 8'h30, 8'h20, 8'h10};
      frame4(v, 0, 0, -1, 0, "basic");
      // Stall on beat 2.
      frame4(v, 2, 0, -1, 0, "stall");
      // Inputs change after the snapshot.
      frame4(v, 0, 1, -1, 0, "snapshot");
      // Reset during beat 2, then a full frame.
      frame4(v, 0, 0, 2, 0, "midreset");
      frame4(v, 0, 0, -1, 0, "after_reset");
      // Checksum wrap pattern, also with a stray start mid-frame.
      v = {8'h02, 8'h01, 8'h20, 8'hF0};
      frame4(v, 0, 0, -1, 2, "wrap_restart");
      // Random values and random backpressure.
      for (int f = 0; f < 8; f++) begin
         for (int i = 0; i < N4; i++) v[i] = 8'($urandom);
         frame4(v, 1, (f % 2) == 1, -1, (f % 3 == 0) ? 3 : 0, "random");
      end

      // Single-pixel instance: stall, stray start, then drain.
      v1 = 8'($urandom_range(1, 255));
      @(negedge clk);
      vals1 = v1; start1 = 1'b1; ready1 = 1'b0;
      @(negedge clk);
      chk("n1_busy", busy1, 1);
      chk("n1_valid", valid1, 1);
      chk("n1_data", data1, v1);
      chk("n1_index", idx1, 0);
      chk("n1_last", last1, (CK == 0));
      vals1 = 8'h00;
      @(negedge clk);
      start1 = 1'b0; ready1 = 1'b1;
      chk("n1_hold_data", data1, v1);
      chk("n1_hold_last", last1, (CK == 0));
      if (CK != 0) begin
         @(negedge clk);
         chk("n1_ck_valid", valid1, 1);
         chk("n1_ck_data", data1, v1);
         chk("n1_ck_index", idx1, 0);
         chk("n1_ck_last", last1, 1);
      end
      @(negedge clk);
      chk("n1_done", done1, 1);
      chk("n1_clr", clr1, 1);
      chk("n1_fin_valid", valid1, 0);
      chk("n1_fin_busy", busy1, 1);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("n1_post_busy", busy1, 0);
         chk("n1_post_valid", valid1, 0);
         chk("n1_post_done", done1, 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/pixel_readout.md
PIXEL_READOUT -- requirements
Module: pixel_readout

Interface
REQ-001 SHALL have parameter NUM_PIXELS, default 1, number of pixel values scanned per frame (legal range 1..256).
REQ-002 SHALL define local IDX_W = max(1, clog2(NUM_PIXELS)).
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-005 SHALL have port start, input, 1 bit, request to read out one frame.
REQ-006 SHALL have port stored_values, input, NUM_PIXELS x 8 bits, per-pixel sampled counter values from the capture array.
REQ-007 SHALL have port out_data, output, 8 bits, current beat payload.
REQ-008 SHALL have port out_index, output, IDX_W bits, pixel number of the current beat.
REQ-009 SHALL have port out_valid, output, 1 bit, beat valid.
REQ-010 SHALL have port out_ready, input, 1 bit, sink accepts beat.
REQ-011 SHALL have port out_last, output, 1 bit, final beat of the frame.
REQ-012 SHALL have port busy, output, 1 bit, readout in progress.
REQ-013 SHALL have port done, output, 1 bit, one-cycle frame-complete pulse.
REQ-014 SHALL have port array_clear, output, 1 bit, one-cycle pulse to clear the capture array.

Function
REQ-015 SHALL implement states IDLE, SEND, CKSUM (macro only), FINISH.
REQ-016 IDLE: start=1 -> snapshot all stored_values into a shadow buffer, idx=0, go to SEND next cycle; busy=1 from that next cycle.
REQ-017 start while not IDLE SHALL be ignored, with no queuing.
REQ-018 SEND: out_valid=1, out_data=shadow[idx], out_index=idx; a beat transfers on out_valid & out_ready.
REQ-019 While out_valid=1 and out_ready=0, out_data, out_index and out_last SHALL hold stable.
REQ-020 On a transfer with idx<NUM_PIXELS-1 -> idx+1, with no bubble: back-to-back beats every cycle when out_ready=1.
REQ-021 On the transfer at idx=NUM_PIXELS-1 -> CKSUM if the macro is defined, else FINISH.
REQ-022 out_last SHALL be 1 only on the final beat of the frame.
REQ-023 FINISH SHALL last one cycle: done=1, array_clear=1, out_valid=0, then go to IDLE with busy=0 in that IDLE cycle.
REQ-024 Frame latency with constant out_ready=1: start at cycle 0 -> first beat cycle 1 -> done at cycle NUM_PIXELS+1 (+1 with checksum).
REQ-025 stored_values changes after the snapshot SHALL NOT affect the frame in flight.
REQ-026 NUM_PIXELS=1: a single beat with out_last=1 and out_index=0.
REQ-027 out_data and out_index SHALL be 0 whenever out_valid=0.

Reset
REQ-028 reset=1 SHALL immediately force IDLE, idx=0, shadow=0, and all outputs 0 (out_data, out_index, out_valid, out_last, busy, done, array_clear).
REQ-029 Reset mid-frame SHALL abort the frame with no done and no array_clear; after release, the block accepts start normally.

Configuration
REQ-030 Macro READOUT_CHECKSUM_EN defined: after the last pixel beat, CKSUM SHALL send one extra beat with out_data = sum of all snapshot values mod 256, out_index=0, out_last=1, under the same backpressure rules; pixel beats then have out_last=0.
REQ-031 Macro undefined: no CKSUM state or adder; the last pixel beat carries out_last=1.

Verification
REQ-032 NUM_PIXELS=4, values {0x10,0x20,0x30,0x40}, out_ready=1, start pulse -> beats 0x10..0x40 on cycles 1-4, out_index 0..3, out_last on 0x40, done+array_clear on cycle 5.
REQ-033 Same frame, out_ready low for 3 cycles on beat 2 -> out_data 0x30 and out_index 2 held stable, no beat lost or duplicated.
REQ-034 Change stored_values to 0xFF one cycle after start -> frame still emits the snapshot {0x10,0x20,0x30,0x40}.
REQ-035 Assert reset during beat 2 -> all outputs 0 that cycle, no done pulse; a new start then gives a complete frame.
REQ-036 READOUT_CHECKSUM_EN, values {0xF0,0x20,0x01,0x02} -> 5th beat 0x13 with out_last=1, pixel beats out_last=0.
REQ-037 start re-pulsed mid-frame and NUM_PIXELS=1 -> extra start ignored, exactly one frame; single beat with out_last=1.
